// File: rtl/ifq_pkg.sv
// Shared types for the instruction fetch queue: default address width and
// the per-edge operation decode used by the queue control.
package ifq_pkg;

  localparam int IFQ_VADDR_W = 32;

  typedef enum logic [1:0] {
    IFQ_IDLE = 2'b00,
    IFQ_PUSH = 2'b01,
    IFQ_POP  = 2'b10,
    IFQ_BOTH = 2'b11
  } ifq_op_e;

  function automatic ifq_op_e ifq_decode(input logic push, input logic pop);
    return ifq_op_e'({pop, push});
  endfunction

endpackage

// File: rtl/ifq.sv
// Instruction fetch queue: DEPTH-entry FIFO of fetch addresses with valid/ready
// handshakes on both sides and a flush that discards everything on redirect.
module ifq
  import ifq_pkg::*;
#(
  parameter int WIDTH = IFQ_VADDR_W,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ifq_valid_in,
  input  logic [WIDTH-1:0] ifq_addr_in,
  output logic             ifq_ready_out,
  output logic             ifq_valid_out,
  output logic [WIDTH-1:0] ifq_addr_out,
  input  logic             ifq_ready_in,
  input  logic             ifq_flush_in,
  output logic [CW-1:0]    ifq_count_out
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [0:DEPTH-1];
  logic [WIDTH-1:0] mem_d [0:DEPTH-1];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q,  count_d;
  logic             push, pop;
  ifq_op_e          op;

  // Outputs come only from registered state, so no input-to-output paths.
  assign ifq_ready_out = (count_q != CW'(DEPTH));
  assign ifq_valid_out = (count_q != '0);
  assign ifq_addr_out  = mem_q[rd_ptr_q];
  assign ifq_count_out = count_q;

  assign push = ifq_valid_in & ifq_ready_out & ~ifq_flush_in;
  assign pop  = ifq_valid_out & ifq_ready_in & ~ifq_flush_in;
  assign op   = ifq_decode(push, pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (ifq_flush_in) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = ifq_addr_in;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case (op)
        IFQ_PUSH: count_d = count_q + CW'(1);
        IFQ_POP:  count_d = count_q - CW'(1);
        default:  count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately left out of reset; stale entries are unreachable.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: doc/ifq.md
IFQ -- requirements
Module: ifq

Interface
REQ-001 Parameter WIDTH, default 32, bit width of each queued fetch address.
REQ-002 Parameter DEPTH, default 4, number of entries; SHALL be a power of two, 2..64.
REQ-003 Parameter CW, default $clog2(DEPTH+1), width of the occupancy count.
REQ-004 clk  input  1  system clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 ifq_valid_in  input  1  upstream offers an address.
REQ-007 ifq_addr_in  input  WIDTH  offered address.
REQ-008 ifq_ready_out  output  1  queue can accept this cycle.
REQ-009 ifq_valid_out  output  1  head entry present.
REQ-010 ifq_addr_out  output  WIDTH  head entry address.
REQ-011 ifq_ready_in  input  1  downstream consumes the head this cycle.
REQ-012 ifq_flush_in  input  1  discard all entries, e.g. on redirect.
REQ-013 ifq_count_out  output  CW  current number of stored entries.

Function
REQ-014 Push SHALL occur on a rising edge when ifq_valid_in & ifq_ready_out & !ifq_flush_in.
REQ-015 Pop SHALL occur on a rising edge when ifq_valid_out & ifq_ready_in & !ifq_flush_in.
REQ-016 ifq_ready_out SHALL be (count != DEPTH), derived from registered state only; there is no combinational path from ifq_ready_in.
REQ-017 ifq_valid_out SHALL be (count != 0); ifq_addr_out SHALL be the oldest stored entry, driven from storage; there is no combinational path from ifq_addr_in or ifq_valid_in.
REQ-018 Latency: an address pushed at edge N SHALL appear at ifq_addr_out, with ifq_valid_out high, no earlier than the cycle after edge N.
REQ-019 Order SHALL be strictly FIFO; no entry is lost, duplicated or reordered.
REQ-020 Simultaneous push and pop SHALL leave count unchanged and advance both pointers, including when count = 1.
REQ-021 When full, ifq_ready_out is low, so no push occurs, even if a pop occurs in the same cycle.
REQ-022 When empty, no pop SHALL occur regardless of ifq_ready_in.
REQ-023 Read and write pointers SHALL be log2(DEPTH) bits wide and wrap modulo DEPTH; full and empty are distinguished by the count register, not by pointer equality.
REQ-024 ifq_flush_in SHALL take priority over push and pop: on that edge count becomes 0 and both pointers become 0, and the concurrently offered input is dropped.
REQ-025 ifq_count_out SHALL equal the registered count, updated as +1 on push only, -1 on pop only, and unchanged otherwise.
REQ-026 Storage contents SHALL NOT need reset; ifq_addr_out is don't-care while ifq_valid_out is low.

Reset
REQ-027 On rst high at a rising edge, count SHALL be 0, both pointers 0, ifq_valid_out 0, ifq_ready_out 1 and ifq_count_out 0 from the following cycle.
REQ-028 rst SHALL override flush, push and pop, and SHALL discard contents mid-operation, with no partial state surviving.

Structure
REQ-029 No shared package is required; WIDTH and DEPTH are module parameters, with the default address width matching the CPU virtual address width of 32.
REQ-030 Storage SHALL be a register array inside ifq; no sub-module is instantiated.
REQ-031 The block SHALL be insertable between existing fetch stages using the valid/ready convention of those stages.

Verification
REQ-032 Reset, then push 0x00004000, 0x00004004, 0x00004008 with ifq_ready_in=0 -> count=3, head=0x00004000, ifq_ready_out=1.
REQ-033 DEPTH=4: push 0x10, 0x14, 0x18, 0x1C, then offer 0x20 -> ifq_ready_out=0, 0x20 not stored; then pop four times -> 0x10, 0x14, 0x18, 0x1C in order, then ifq_valid_out=0.
REQ-034 Continuous push of an incrementing stream 0x0000603C.. with ifq_ready_in=1 every cycle for 20 cycles -> count stays at 1 after the first push, output sequence equals input delayed by one cycle, and pointers wrap cleanly.
REQ-035 With count=3, assert ifq_flush_in together with a valid push of 0xDEAD0000 and ifq_ready_in=1 -> next cycle count=0, ifq_valid_out=0, and 0xDEAD0000 is not delivered.
REQ-036 With count=2 mid-stream, assert rst for one cycle -> next cycle count=0 and ifq_ready_out=1; a subsequent push of 0x00000100 is delivered first.
REQ-037 Randomised valid/ready and occasional flush over 10000 cycles, checked against a scoreboard model -> zero ordering or count mismatches.
